// File: rtl/riscv_mem_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package riscv_mem_pkg;

    typedef enum logic [1:0] {
        ARB     = 2'd0,
        DATA    = 2'd1,
        FETCH   = 2'd2,
        RELEASE = 2'd3
    } arb_state_e;

    localparam logic [31:0] NOP_INSTR       = 32'h0000_0013;
    localparam int unsigned DEF_TIMEOUT_CYC = 32'd255;

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-state counter for one memory transfer; pulses o_timeout on the last
// allowed cycle of a transfer that has not been acknowledged.
module mem_wait_timer
    import riscv_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_timeout
);

    localparam int unsigned CNT_W = (TIMEOUT_CYC > 32'd1) ? $clog2(TIMEOUT_CYC) : 32'd1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYC - 32'd1);

    logic [CNT_W-1:0] r_count;

    // Count unacknowledged request cycles; clear has priority so a new transfer starts at zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + CNT_W'(1);
        end else begin
            r_count <= r_count;
        end
    end

    assign o_timeout = i_en && (r_count == LAST_CNT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares a single-ported memory between fetch and M-stage load/store: each
// pipeline step serves data first, then fetch, then releases for one cycle.
module mem_port_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] PCF,
    output logic [DATA_W-1:0] InstrF,
    input  logic [ADDR_W-1:0] ALUResultM,
    input  logic [DATA_W-1:0] WriteDataM,
    input  logic              MemWriteM,
    input  logic              MemReadM,
    output logic [DATA_W-1:0] ReadDataM,
    output logic              StallMem,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              bus_err
);

    localparam logic [DATA_W-1:0] NOP_W = DATA_W'(NOP_INSTR);

    arb_state_e r_state;
    arb_state_e w_next;
    logic       w_timeout;
    logic       w_done;
    logic       w_wait_en;
    logic       w_clr;
    logic       w_is_load;

    // A simultaneous read+write request is treated as a store.
    assign w_is_load = MemReadM & ~MemWriteM;
    assign w_wait_en = mem_req & ~mem_ack;
    assign w_done    = mem_ack | w_timeout;
    assign w_clr     = (w_next != r_state);

    mem_wait_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wait_timer (
        .i_clk     (clk),
        .i_rst_n   (rst),
        .i_clr     (w_clr),
        .i_en      (w_wait_en),
        .o_timeout (w_timeout)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ARB;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ARB:     w_next = (MemReadM | MemWriteM) ? DATA : FETCH;
            DATA:    w_next = w_done ? FETCH : DATA;
            FETCH:   w_next = w_done ? RELEASE : FETCH;
            RELEASE: w_next = ARB;
            default: w_next = ARB;
        endcase
    end

    // Bus and stall outputs decoded from the state register.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        StallMem  = 1'b1;
        case (r_state)
            DATA: begin
                mem_req   = 1'b1;
                mem_we    = MemWriteM;
                mem_addr  = ALUResultM;
                mem_wdata = WriteDataM;
            end
            FETCH: begin
                mem_req   = 1'b1;
                mem_addr  = PCF;
            end
            RELEASE: begin
                StallMem  = 1'b0;
            end
            ARB: begin
                StallMem  = 1'b1;
            end
            default: begin
                StallMem  = 1'b1;
            end
        endcase
    end

    // Capture returned data; a timed-out transfer substitutes a safe value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            InstrF    <= NOP_W;
            ReadDataM <= '0;
            bus_err   <= 1'b0;
        end else begin
            if ((r_state == DATA) && w_done && w_is_load) begin
                ReadDataM <= mem_ack ? mem_rdata : '0;
            end else begin
                ReadDataM <= ReadDataM;
            end
            if ((r_state == FETCH) && w_done) begin
                InstrF <= mem_ack ? mem_rdata : NOP_W;
            end else begin
                InstrF <= InstrF;
            end
            if (w_timeout) begin
                bus_err <= 1'b1;
            end else begin
                bus_err <= bus_err;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: directed scenarios plus random steps against a
// per-step timeline model of the arbiter.
module tb_mem_port_arbiter;
    import riscv_mem_pkg::*;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PCF, ALUResultM, WriteDataM, mem_rdata;
    logic        MemWriteM, MemReadM, mem_ack;
    logic [31:0] InstrF, ReadDataM, mem_addr, mem_wdata;
    logic        StallMem, mem_req, mem_we, bus_err;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_instr;
    logic [31:0] m_rd;
    logic        m_err;

    mem_port_arbiter #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .PCF        (PCF),
        .InstrF     (InstrF),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .MemWriteM  (MemWriteM),
        .MemReadM   (MemReadM),
        .ReadDataM  (ReadDataM),
        .StallMem   (StallMem),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .bus_err    (bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_bus(input string ph, input logic e_req, input logic e_we,
                           input logic [31:0] e_addr, input logic [31:0] e_wdata,
                           input logic e_stall);
        chk({ph, " mem_req"},   32'(mem_req),  32'(e_req));
        chk({ph, " mem_we"},    32'(mem_we),   32'(e_we));
        chk({ph, " mem_addr"},  mem_addr,      e_addr);
        chk({ph, " mem_wdata"}, mem_wdata,     e_wdata);
        chk({ph, " StallMem"},  32'(StallMem), 32'(e_stall));
    endtask

    // One memory transfer: ack arrives after lat wait cycles unless the timeout hits first.
    task automatic mem_phase(input string ph, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input int lat,
                             input logic [31:0] rdata, output logic acked);
        int n;
        n     = (lat < TO) ? lat + 1 : TO;
        acked = (lat < TO);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            mem_ack   = (c == lat);
            mem_rdata = (c == lat) ? rdata : $urandom;
            #1;
            chk_bus(ph, 1'b1, we, addr, wdata, 1'b1);
        end
    endtask

    // One full pipeline step; entered just after a negedge with the arbiter in ARB.
    task automatic step(input logic rd, input logic wr, input logic [31:0] alu,
                        input logic [31:0] wd, input logic [31:0] pc,
                        input int lat_d, input int lat_f,
                        input logic [31:0] rdat_d, input logic [31:0] rdat_f);
        logic acked;
        MemReadM   = rd;
        MemWriteM  = wr;
        ALUResultM = alu;
        WriteDataM = wd;
        PCF        = pc;
        mem_ack    = 1'($urandom);
        mem_rdata  = $urandom;
        #1;
        chk_bus("arb", 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
        if (rd | wr) begin
            mem_phase("data", wr, alu, wd, lat_d, rdat_d, acked);
            if (!acked) m_err = 1'b1;
            if (rd & !wr) m_rd = acked ? rdat_d : 32'd0;
        end
        mem_phase("fetch", 1'b0, pc, 32'd0, lat_f, rdat_f, acked);
        if (!acked) m_err = 1'b1;
        m_instr = acked ? rdat_f : NOP_INSTR;
        @(negedge clk);
        mem_ack   = 1'($urandom);
        mem_rdata = $urandom;
        #1;
        chk_bus("release", 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        chk("InstrF",    InstrF,        m_instr);
        chk("ReadDataM", ReadDataM,     m_rd);
        chk("bus_err",   32'(bus_err),  32'(m_err));
        @(negedge clk);
    endtask

    initial begin
        int kind;
        rst        = 1'b0;
        PCF        = 32'd0;
        ALUResultM = 32'd0;
        WriteDataM = 32'd0;
        MemWriteM  = 1'b0;
        MemReadM   = 1'b0;
        mem_ack    = 1'b0;
        mem_rdata  = 32'd0;
        m_instr    = NOP_INSTR;
        m_rd       = 32'd0;
        m_err      = 1'b0;

        repeat (3) @(negedge clk);
        #1;
        chk("rst InstrF",    InstrF,         NOP_INSTR);
        chk("rst ReadDataM", ReadDataM,      32'd0);
        chk("rst StallMem",  32'(StallMem),  32'd1);
        chk("rst mem_req",   32'(mem_req),   32'd0);
        chk("rst bus_err",   32'(bus_err),   32'd0);
        @(negedge clk);
        rst = 1'b1;

        // fetch-only, zero wait, repeated to show the 3-cycle period
        step(1'b0, 1'b0, 32'd0, 32'd0, 32'h100, 0, 0, 32'd0, 32'h0050_0093);
        step(1'b0, 1'b0, 32'd0, 32'd0, 32'h104, 0, 0, 32'd0, 32'h0010_0113);
        // store then fetch
        step(1'b0, 1'b1, 32'h2000, 32'hDEAD_BEEF, 32'h104, 0, 0, 32'd0, 32'h0020_0193);
        // load with ack on the third request cycle
        step(1'b1, 1'b0, 32'h40, 32'h0, 32'h108, 2, 0, 32'h1234_5678, 32'h0030_0213);
        // ack in the timeout cycle wins
        step(1'b0, 1'b0, 32'd0, 32'd0, 32'h10C, TO - 1, 0, 32'd0, 32'hCAFE_0001);
        step(1'b1, 1'b0, 32'h44, 32'h0, 32'h110, TO - 1, 0, 32'h5555_AAAA, 32'h0040_0293);
        // fetch timeout, then sticky error across a clean step
        step(1'b0, 1'b0, 32'd0, 32'd0, 32'h114, 100, 0, 32'd0, 32'hFFFF_FFFF);
        step(1'b0, 1'b0, 32'd0, 32'd0, 32'h118, 0, 0, 32'd0, 32'h0050_0313);
        // load timeout zeroes ReadDataM; store timeout is dropped
        step(1'b1, 1'b0, 32'h48, 32'h0, 32'h11C, 100, 1, 32'hFFFF_FFFF, 32'h0060_0393);
        step(1'b0, 1'b1, 32'h4C, 32'h1111_2222, 32'h120, 100, 0, 32'd0, 32'h0070_0413);

        // reset asserted two cycles into a fetch wait
        MemReadM  = 1'b0;
        MemWriteM = 1'b0;
        PCF       = 32'h200;
        mem_ack   = 1'b0;
        #1;
        chk_bus("rst6 arb", 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            mem_ack = 1'b0;
            #1;
            chk_bus("rst6 fetch", 1'b1, 1'b0, 32'h200, 32'd0, 1'b1);
        end
        rst = 1'b0;
        #1;
        chk("rst6 mem_req",  32'(mem_req),  32'd0);
        chk("rst6 StallMem", 32'(StallMem), 32'd1);
        chk("rst6 InstrF",   InstrF,        NOP_INSTR);
        chk("rst6 bus_err",  32'(bus_err),  32'd0);
        m_instr = NOP_INSTR;
        m_rd    = 32'd0;
        m_err   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        step(1'b0, 1'b0, 32'd0, 32'd0, 32'h204, 0, 0, 32'd0, 32'h0080_0493);

        // random steps: none / load / store / illegal both
        for (int i = 0; i < 40; i++) begin
            kind = int'($urandom_range(0, 3));
            step(kind == 1 || kind == 3, kind == 2 || kind == 3,
                 $urandom, $urandom, $urandom,
                 int'($urandom_range(0, 9)), int'($urandom_range(0, 9)),
                 $urandom, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, variable-latency memory between instruction fetch (PCF) and the M-stage load/store of the 5-stage pipelined RISC-V datapath.
- Per pipeline step it serves the data access first (if any), then the fetch, then releases the pipeline for exactly one cycle.
- StallMem feeds the hazard unit and freezes every pipeline register, including the M/W registers.

Parameters:
- ADDR_W, 32, memory address width.
- DATA_W, 32, memory data width.
- TIMEOUT_CYC, 255, maximum req-without-ack cycles before bus error (2..65535).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- PCF  in  ADDR_W  fetch address.
- InstrF  out  DATA_W  fetched instruction to the fetch stage; registered.
- ALUResultM  in  ADDR_W  data address.
- WriteDataM  in  DATA_W  store data.
- MemWriteM  in  1  store request.
- MemReadM  in  1  load request.
- ReadDataM  out  DATA_W  load data to the memory stage; registered.
- StallMem  out  1  1 = freeze the whole pipeline.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid with mem_ack.
- mem_ack  in  1  transfer complete; may be high in the same cycle as mem_req.
- bus_err  out  1  sticky timeout flag.

Behaviour:
- Reset (rst=0, async): state=ARB, InstrF=32'h00000013 (NOP), ReadDataM=0, bus_err=0, wait counter=0. Outputs during reset: mem_req=0, StallMem=1.
- States: ARB, DATA, FETCH, RELEASE.
- ARB: StallMem=1, mem_req=0. Goes to DATA if MemReadM|MemWriteM, else to FETCH.
- DATA:
  - Drives mem_req=1, mem_we=MemWriteM, mem_addr=ALUResultM, mem_wdata=WriteDataM.
  - A transfer completes on the edge where mem_req&mem_ack.
  - On completion: if MemReadM, ReadDataM<=mem_rdata; a store leaves ReadDataM unchanged. Then go to FETCH.
- FETCH:
  - Drives mem_req=1, mem_we=0, mem_addr=PCF, mem_wdata=0.
  - On completion: InstrF<=mem_rdata, then go to RELEASE.
- RELEASE: StallMem=0 for exactly one cycle; the pipeline advances on this edge. mem_req=0. Go to ARB.
- Outside DATA/FETCH: mem_we=0, mem_addr=0, mem_wdata=0.
- Step latency with zero-wait memory: 3 cycles fetch-only, 4 cycles with a data access. Each memory wait state adds 1 cycle.
- mem_req is never withdrawn before ack or timeout. mem_addr, mem_we and mem_wdata are stable while mem_req=1; this holds because the pipeline is frozen.
- MemReadM=1 and MemWriteM=1 together is illegal and is handled as a store.
- Wait counter:
  - Cleared on entry to DATA/FETCH; increments each cycle mem_req=1 and mem_ack=0.
  - When it reaches TIMEOUT_CYC-1 with no ack, the transfer is forced complete: bus_err<=1 (sticky until reset).
  - Forced values: FETCH loads InstrF<=NOP; DATA loads ReadDataM<=0 for a load; a store is dropped.
  - The FSM proceeds as if acked.
- An ack in the timeout cycle wins; bus_err is not set.
- Reset asserted mid-transfer: mem_req drops immediately and the state returns to ARB. The pending transfer is abandoned and the memory must tolerate that.
- PCSrcE/Flush redirects need no arbiter action; the new PCF is fetched in the next step.

Decomposition:
- Package riscv_mem_pkg holds:
  - the state enum (ARB, DATA, FETCH, RELEASE), 2-bit encoding;
  - the constant NOP_INSTR=32'h00000013;
  - the default TIMEOUT_CYC.
- Sub-module mem_wait_timer: clear/enable counter, width clog2(TIMEOUT_CYC), output timeout pulse. Instantiated once.

Test Plan:
1. rst=0 for 3 cycles -> InstrF=32'h00000013, ReadDataM=0, StallMem=1, mem_req=0, bus_err=0; after release the state is ARB.
2. Fetch-only, mem_ack tied 1, PCF=32'h100, mem_rdata=32'h00500093 -> mem_req=1 one cycle with addr=32'h100, we=0; StallMem low exactly 1 cycle in every 3; InstrF=32'h00500093.
3. Store, MemWriteM=1, ALUResultM=32'h2000, WriteDataM=32'hDEADBEEF, PCF=32'h104, ack tied 1 -> first transfer we=1, addr=32'h2000, wdata=32'hDEADBEEF; then we=0, addr=32'h104; period 4 cycles; ReadDataM unchanged.
4. Load, MemReadM=1, ALUResultM=32'h40, ack 3 cycles after req with rdata=32'h12345678 -> mem_req held 3 cycles with stable addr=32'h40; ReadDataM=32'h12345678 by RELEASE; bus_err=0.
5. TIMEOUT_CYC=8, fetch, mem_ack never -> mem_req high exactly 8 cycles; bus_err=1 and stays 1 across later steps; InstrF=32'h00000013; RELEASE still occurs.
6. rst driven low 2 cycles into a FETCH wait -> mem_req=0 in the same cycle (async); after release the sequence restarts at ARB with an identical 3-cycle fetch step.
